// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit controller slice.
//   tx_state_t : FSM state type and encoding (also driven on dbg_state)
//   PAR_EVEN / PAR_ODD : parity-type constants carried on par_typ
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational parity bit for one data word.
//   i_data    : word to protect
//   i_par_typ : PAR_EVEN or PAR_ODD
//   o_parity  : bit that makes the total count of ones even (PAR_EVEN) or
//               odd (PAR_ODD) over data plus parity
// ---------------------------------------------------------------------------
module parity_calc
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_par_typ,
  output logic              o_parity
);

  assign o_parity = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Frame controller for a UART transmitter that pairs with an external
// serializer. Sequences START, DATA (LSB first, bits from s_data), optional
// PARITY and STOP, and drives the line.
//
// Build option: define UART_TX_PARITY_EN to add par_en/par_typ and the
// PARITY state. Without it every frame goes DATA -> STOP.
//
// Ports
//   clk        : clock, one line bit per cycle
//   rst        : asynchronous, active-low reset
//   data_valid : request to send p_data
//   p_data     : parallel word to send
//   par_en     : parity enable (UART_TX_PARITY_EN only)
//   par_typ    : 0 even / 1 odd (UART_TX_PARITY_EN only)
//   s_data     : serial bit from the serializer (already registered there)
//   ser_done   : serializer last-bit flag, honoured only in DATA
//   ser_en     : serializer enable, high for exactly DWIDTH cycles per frame
//   ser_data   : word latched at accept, feeds the serializer
//   tx_out     : UART line
//   tx_ready   : a word is accepted this cycle if data_valid is high
//   busy       : frame in progress
//   dbg_state  : current FSM state (tx_state_t encoding)
//
// Handshake: a word is accepted on a rising clk edge where data_valid and
// tx_ready are both high. tx_ready depends only on state (IDLE or STOP), so
// data_valid may be held across frames; while tx_ready is low, data_valid
// and p_data are ignored.
// ---------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DWIDTH-1:0] p_data,
`ifdef UART_TX_PARITY_EN
  input  logic              par_en,
  input  logic              par_typ,
`endif
  input  logic              s_data,
  input  logic              ser_done,
  output logic              ser_en,
  output logic [DWIDTH-1:0] ser_data,
  output logic              tx_out,
  output logic              tx_ready,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DWIDTH - 2);

  tx_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_ser_en;
  logic [DWIDTH-1:0] r_ser_data;
  logic              r_par;
  logic              w_par;
  logic              w_tx_ready;
  logic              w_accept;
  logic              w_par_active;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  assign w_par_active = r_par_en;

  parity_calc #(.DWIDTH(DWIDTH)) u_parity (
    .i_data    (p_data),
    .i_par_typ (par_typ),
    .o_parity  (w_par)
  );
`else
  assign w_par_active = 1'b0;

  parity_calc #(.DWIDTH(DWIDTH)) u_parity (
    .i_data    (p_data),
    .i_par_typ (PAR_EVEN),
    .o_parity  (w_par)
  );
`endif

  assign w_tx_ready = (r_state == ST_IDLE) || (r_state == ST_STOP);
  assign w_accept   = data_valid & w_tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ser_en   <= 1'b0;
      r_ser_data <= '0;
      r_par      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_STOP: begin
          if (w_accept) begin
            r_state    <= ST_START;
            r_cnt      <= '0;
            r_ser_en   <= 1'b1;
            r_ser_data <= p_data;
            r_par      <= w_par;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= par_en;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          r_state <= ST_DATA;
          r_cnt   <= '0;
        end
        ST_DATA: begin
          // Counter saturates at the last bit index rather than wrapping.
          if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
          // START already used one enable cycle, so drop it one bit early.
          if (r_cnt == CNT_PRE) r_ser_en <= 1'b0;
          if (ser_done) begin
            r_ser_en <= 1'b0;
            r_state  <= w_par_active ? ST_PARITY : ST_STOP;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          r_state <= ST_STOP;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Line mux: every leg is a flop (state, serializer bit, parity register).
  always_comb begin
    tx_out = 1'b1;
    case (r_state)
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = s_data;
      ST_PARITY: tx_out = r_par;
      default:   tx_out = 1'b1;
    endcase
  end

  assign ser_en    = r_ser_en;
  assign ser_data  = r_ser_data;
  assign tx_ready  = w_tx_ready;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, number of data bits per frame (>=2).
REQ-002 SHALL have port clk  input  1  bit clock, one line bit per cycle.
REQ-003 SHALL have port rst  input  1  reset; rst is asynchronous, active-low; clock is clk.
REQ-004 SHALL have port data_valid  input  1  request to send p_data.
REQ-005 SHALL have port p_data  input  DWIDTH  parallel word to send.
REQ-006 SHALL have port par_en  input  1  parity bit enable (UART_TX_PARITY_EN builds only).
REQ-007 SHALL have port par_typ  input  1  0 = even, 1 = odd (UART_TX_PARITY_EN builds only).
REQ-008 SHALL have port s_data  input  1  serializer serial bit (registered in serializer).
REQ-009 SHALL have port ser_done  input  1  serializer last-bit flag.
REQ-010 SHALL have port ser_en  output  1  serializer enable.
REQ-011 SHALL have port ser_data  output  DWIDTH  latched word driven to serializer p_data.
REQ-012 SHALL have port tx_out  output  1  UART line.
REQ-013 SHALL have port tx_ready  output  1  word can be accepted this cycle.
REQ-014 SHALL have port busy  output  1  frame in progress.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 Accept = data_valid & tx_ready; tx_ready high in IDLE and STOP only; accept latches p_data into ser_data (and par_en/par_typ), next state START.
REQ-017 data_valid outside IDLE/STOP SHALL be ignored; p_data changes after accept SHALL not affect the frame.
REQ-018 START: one cycle, tx_out = 0, ser_en = 1; next DATA.
REQ-019 ser_en SHALL be high for exactly DWIDTH consecutive cycles: START plus first DWIDTH-1 DATA cycles; low in last DATA cycle; internal bit counter 0..DWIDTH-1, no wrap.
REQ-020 DATA: DWIDTH cycles, tx_out = s_data (LSB first); exit on ser_done = 1 to PARITY if parity active, else STOP.
REQ-021 ser_done outside DATA SHALL be ignored.
REQ-022 PARITY: one cycle, tx_out = XOR(ser_data) ^ par_typ; next STOP.
REQ-023 STOP: one cycle, tx_out = 1; next START on accept, else IDLE.
REQ-024 IDLE: tx_out = 1, ser_en = 0.
REQ-025 busy SHALL be high in START, DATA, PARITY, STOP; low in IDLE.
REQ-026 tx_out SHALL be a mux of registered signals only (state, s_data, parity register).
REQ-027 Frame length SHALL be DWIDTH+2 cycles, +1 when parity active; back-to-back frames SHALL have no idle gap.

Reset
REQ-028 On rst low: state IDLE, tx_out = 1, ser_en = 0, busy = 0, tx_ready = 1, ser_data = 0, counter = 0, parity register = 0.
REQ-029 Reset mid-frame SHALL abort immediately; no partial frame resumes after release; first accept after release starts a fresh START.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: par_en/par_typ ports and PARITY state present; parity active when latched par_en = 1.
REQ-031 Macro undefined: ports and PARITY state absent; DATA always goes to STOP.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state type/encoding and parity-type constants (PAR_EVEN = 0, PAR_ODD = 1).
REQ-033 Parity SHALL be computed in sub-module parity_calc (DWIDTH-wide XOR plus type), registered on accept.

Verification
REQ-034 Macro on, par_en = 1, even, p_data = 8'hA5, one-cycle data_valid -> tx_out 0,1,0,1,0,0,1,0,1,0,1; busy high 11 cycles.
REQ-035 Macro on, par_en = 1, odd, p_data = 8'h83 -> data bits 1,1,0,0,0,0,0,1, parity 0, stop 1.
REQ-036 par_en = 0 (or macro off), 8'h3C then 8'hC3 with data_valid held -> two 10-cycle frames, START of second directly after first STOP.
REQ-037 data_valid pulsed with 8'hFF during DATA of 8'h00 frame -> 8'h00 frame unchanged, 8'hFF never sent.
REQ-038 rst low during DATA bit 4 -> tx_out = 1, busy = 0, ser_en = 0 same cycle; stays IDLE until next accept.
REQ-039 Every frame -> ser_en high exactly DWIDTH cycles, ser_done seen in last DATA cycle.
